character_motion_ctrl: RTL and testbench



---
 rtl/character_motion_ctrl_pkg.sv | 26 ++
 rtl/character_motion_ctrl_if.sv | 28 ++
 rtl/character_motion_ctrl_hit_window_detect.sv | 50 +++++
 rtl/character_motion_ctrl.sv | 129 ++++++++++++
 tb/tb_character_motion_ctrl.sv | 179 +++++++++++++++++
 5 files changed

// File: rtl/character_motion_ctrl_pkg.sv
// Shared action-state codes and arena constants for the
// action state machine and the character motion controller.
package character_motion_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_IDLE       = 3'd0,
      ST_BACKWARD   = 3'd1,
      ST_FORWARD    = 3'd2,
      ST_ATTACK     = 3'd3,
      ST_DIR_ATTACK = 3'd4
   } action_e;

   localparam int ATK_CNT_MAX = 23;
   localparam int DIR_CNT_MAX = 22;
   localparam int ARENA_W     = 640;
   localparam int BODY_W      = 64;
   localparam int SCREEN_W    = 640;
   localparam int SCREEN_H    = 480;
   localparam int XW          = 10;
   localparam int CW          = 5;

   function automatic logic signed [11:0] s12(input int v);
      return $signed(12'(v));
   endfunction

endpackage

// File: rtl/character_motion_ctrl_if.sv
// Per-player motion bundle between the action state machine,
// this controller and the health/score stage.
interface character_motion_ctrl_if;
   import character_motion_ctrl_pkg::*;

   logic          i_frame_tick;
   logic [2:0]    i_state;
   logic [CW-1:0] i_count;
   logic          i_facing_right;
   logic [XW-1:0] i_opp_x;
   logic [XW-1:0] o_x;
   logic          o_hitbox_active;
   logic          o_hit;
   logic [3:0]    o_damage;

   modport master (
      output i_frame_tick, i_state, i_count,
      output i_facing_right, i_opp_x,
      input  o_x, o_hitbox_active, o_hit, o_damage
   );

   modport slave (
      input  i_frame_tick, i_state, i_count,
      input  i_facing_right, i_opp_x,
      output o_x, o_hitbox_active, o_hit, o_damage
   );

endinterface

// File: rtl/character_motion_ctrl_hit_window_detect.sv
// Combinational attack window and hitbox/hurtbox overlap test,
// shared with the opponent instance and the debug overlay.
module hit_window_detect
   import character_motion_ctrl_pkg::*;
#(
   parameter int P_WIDTH      = BODY_W,
   parameter int P_REACH      = 40,
   parameter int P_ATK_ACT_LO = 6,
   parameter int P_ATK_ACT_HI = 11,
   parameter int P_DIR_ACT_LO = 8,
   parameter int P_DIR_ACT_HI = 13
) (
   input  logic [XW-1:0] x,
   input  logic          facing_right,
   input  logic [XW-1:0] opp_x,
   input  logic [2:0]    state,
   input  logic [CW-1:0] count,
   output logic          active,
   output logic          overlap
);

   logic signed [11:0] x_s;
   logic signed [11:0] opp_s;
   logic signed [11:0] hb_lo;
   logic signed [11:0] hb_hi;

   always_comb begin
      x_s   = $signed({2'b00, x});
      opp_s = $signed({2'b00, opp_x});
      hb_lo = facing_right ? x_s + s12(P_WIDTH)
                           : x_s - s12(P_REACH);
      hb_hi = facing_right ? x_s + s12(P_WIDTH + P_REACH)
                           : x_s;
      // half-open intervals on both boxes
      overlap = (hb_lo < opp_s + s12(P_WIDTH)) &&
                (opp_s < hb_hi);
      active = 1'b0;
      case (state)
         ST_ATTACK:
            active = (count >= CW'(P_ATK_ACT_LO)) &&
                     (count <= CW'(P_ATK_ACT_HI));
         ST_DIR_ATTACK:
            active = (count >= CW'(P_DIR_ACT_LO)) &&
                     (count <= CW'(P_DIR_ACT_HI));
         default:
            active = 1'b0;
      endcase
   end

endmodule

// File: rtl/character_motion_ctrl.sv
// Per-frame position integration with arena/opponent clamping,
// plus registered hitbox window and single-shot hit pulse.
module character_motion_ctrl
   import character_motion_ctrl_pkg::*;
#(
   parameter int P_INIT_X      = 100,
   parameter int P_X_MIN       = 0,
   parameter int P_X_MAX       = ARENA_W,
   parameter int P_WIDTH       = BODY_W,
   parameter int P_FWD_SPEED   = 3,
   parameter int P_BWD_SPEED   = 2,
   parameter int P_LUNGE_SPEED = 4,
   parameter int P_REACH       = 40,
   parameter int P_ATK_ACT_LO  = 6,
   parameter int P_ATK_ACT_HI  = 11,
   parameter int P_DIR_ACT_LO  = 8,
   parameter int P_DIR_ACT_HI  = 13,
   parameter int P_DMG_NEUTRAL = 5,
   parameter int P_DMG_DIR     = 8
) (
   input logic clk,
   input logic nRst,
   character_motion_ctrl_if.slave bus
);

   logic [XW-1:0]      x_q;
   logic [XW-1:0]      x_nxt;
   logic               act_q;
   logic               hit_q;
   logic [3:0]         dmg_q;
   logic               latch_q;
   logic               win_active;
   logic               win_overlap;
   logic               in_attack;
   logic               hit_fire;
   logic signed [11:0] x_s;
   logic signed [11:0] opp_s;
   logic signed [11:0] step;
   logic signed [11:0] nx;
   logic               fwd;
   logic               body_ovl;
   logic               ahead;

   hit_window_detect #(
      .P_WIDTH      (P_WIDTH),
      .P_REACH      (P_REACH),
      .P_ATK_ACT_LO (P_ATK_ACT_LO),
      .P_ATK_ACT_HI (P_ATK_ACT_HI),
      .P_DIR_ACT_LO (P_DIR_ACT_LO),
      .P_DIR_ACT_HI (P_DIR_ACT_HI)
   ) u_hwd (
      .x            (x_q),
      .facing_right (bus.i_facing_right),
      .opp_x        (bus.i_opp_x),
      .state        (bus.i_state),
      .count        (bus.i_count),
      .active       (win_active),
      .overlap      (win_overlap)
   );

   always_comb begin
      x_s   = $signed({2'b00, x_q});
      opp_s = $signed({2'b00, bus.i_opp_x});
      step  = '0;
      case (bus.i_state)
         ST_FORWARD:  step = s12(P_FWD_SPEED);
         ST_BACKWARD: step = -s12(P_BWD_SPEED);
         ST_DIR_ATTACK:
            if (bus.i_count < CW'(P_DIR_ACT_LO))
               step = s12(P_LUNGE_SPEED);
         default:     step = '0;
      endcase
      fwd = (step > 12'sd0);
      nx  = bus.i_facing_right ? x_s + step : x_s - step;
      if (nx < s12(P_X_MIN))
         nx = s12(P_X_MIN);
      else if (nx > s12(P_X_MAX - P_WIDTH))
         nx = s12(P_X_MAX - P_WIDTH);
      body_ovl = (x_s < opp_s + s12(P_WIDTH)) &&
                 (opp_s < x_s + s12(P_WIDTH));
      ahead = bus.i_facing_right ?
              (opp_s >= x_s + s12(P_WIDTH)) :
              (opp_s + s12(P_WIDTH) <= x_s);
      // an opponent behind us never limits a forward step
      if (fwd) begin
         if (body_ovl)
            nx = x_s;
         else if (ahead && bus.i_facing_right) begin
            if (nx > opp_s - s12(P_WIDTH))
               nx = opp_s - s12(P_WIDTH);
         end else if (ahead) begin
            if (nx < opp_s + s12(P_WIDTH))
               nx = opp_s + s12(P_WIDTH);
         end
      end
      x_nxt = nx[XW-1:0];
   end

   always_comb begin
      in_attack = (bus.i_state == ST_ATTACK) ||
                  (bus.i_state == ST_DIR_ATTACK);
      hit_fire  = win_active && win_overlap && !latch_q;
   end

   always_ff @(posedge clk or negedge nRst) begin
      if (!nRst) begin
         x_q     <= XW'(P_INIT_X);
         act_q   <= 1'b0;
         hit_q   <= 1'b0;
         dmg_q   <= '0;
         latch_q <= 1'b0;
      end else begin
         if (bus.i_frame_tick)
            x_q <= x_nxt;
         act_q   <= win_active;
         hit_q   <= hit_fire;
         if (hit_fire)
            dmg_q <= (bus.i_state == ST_DIR_ATTACK) ?
                     4'(P_DMG_DIR) : 4'(P_DMG_NEUTRAL);
         latch_q <= in_attack && (latch_q || hit_fire);
      end
   end

   assign bus.o_x             = x_q;
   assign bus.o_hitbox_active = act_q;
   assign bus.o_hit           = hit_q;
   assign bus.o_damage        = dmg_q;

endmodule

// File: tb/tb_character_motion_ctrl.sv
// Directed-vector bench for character_motion_ctrl.
// Expected values are hand-computed from the motion/hit rules.
module tb_character_motion_ctrl;
   import character_motion_ctrl_pkg::*;

   logic clk;
   logic nRst;
   int   vectors;
   int   errors;
   int   hits;

   character_motion_ctrl_if bus ();

   character_motion_ctrl dut (
      .clk  (clk),
      .nRst (nRst),
      .bus  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag,
                      input int got, input int exp);
      vectors++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d",
                  tag, got, exp);
      end
   endtask

   task automatic cyc(input logic [2:0] st,
                      input int cnt, input logic tick);
      bus.i_state      = st;
      bus.i_count      = 5'(cnt);
      bus.i_frame_tick = tick;
      @(posedge clk);
      #1;
      if (bus.o_hit) hits++;
   endtask

   task automatic do_reset();
      bus.i_state      = ST_IDLE;
      bus.i_count      = '0;
      bus.i_frame_tick = 1'b0;
      nRst = 1'b0;
      #2;
      @(negedge clk);
      nRst = 1'b1;
      @(posedge clk);
      #1;
      hits = 0;
   endtask

   initial begin
      vectors = 0;
      errors  = 0;
      hits    = 0;
      nRst    = 1'b0;
      bus.i_frame_tick   = 1'b0;
      bus.i_state        = ST_IDLE;
      bus.i_count        = '0;
      bus.i_facing_right = 1'b1;
      bus.i_opp_x        = 10'd400;
      repeat (3) @(posedge clk);
      #1;
      do_reset();
      chk("rst_x", int'(bus.o_x), 100);
      chk("rst_act", int'(bus.o_hitbox_active), 0);
      chk("rst_hit", int'(bus.o_hit), 0);
      chk("rst_dmg", int'(bus.o_damage), 0);

      for (int i = 0; i < 50; i++) cyc(ST_FORWARD, 0, 1'b0);
      chk("no_tick_hold", int'(bus.o_x), 100);

      for (int i = 0; i < 10; i++) cyc(ST_FORWARD, 0, 1'b1);
      chk("fwd_right", int'(bus.o_x), 130);

      do_reset();
      bus.i_facing_right = 1'b0;
      for (int i = 0; i < 10; i++) cyc(ST_FORWARD, 0, 1'b1);
      chk("fwd_left", int'(bus.o_x), 70);
      for (int i = 0; i < 23; i++) cyc(ST_FORWARD, 0, 1'b1);
      chk("fwd_left_to1", int'(bus.o_x), 1);
      bus.i_facing_right = 1'b1;
      cyc(ST_BACKWARD, 0, 1'b1);
      chk("bwd_clamp0", int'(bus.o_x), 0);
      cyc(ST_BACKWARD, 0, 1'b1);
      chk("bwd_hold0", int'(bus.o_x), 0);

      do_reset();
      bus.i_facing_right = 1'b0;
      bus.i_opp_x        = 10'd0;
      for (int i = 0; i < 115; i++) cyc(ST_BACKWARD, 0, 1'b1);
      chk("bwd_left_330", int'(bus.o_x), 330);
      bus.i_facing_right = 1'b1;
      bus.i_opp_x        = 10'd400;
      cyc(ST_FORWARD, 0, 1'b1);
      chk("opp_blk1", int'(bus.o_x), 333);
      cyc(ST_FORWARD, 0, 1'b1);
      chk("opp_blk2", int'(bus.o_x), 336);
      cyc(ST_FORWARD, 0, 1'b1);
      chk("opp_blk3", int'(bus.o_x), 336);
      cyc(ST_FORWARD, 0, 1'b1);
      chk("opp_blk4", int'(bus.o_x), 336);
      cyc(ST_BACKWARD, 0, 1'b1);
      chk("opp_back", int'(bus.o_x), 334);

      do_reset();
      bus.i_facing_right = 1'b1;
      bus.i_opp_x        = 10'd184;
      for (int c = 0; c <= 23; c++) begin
         cyc(ST_ATTACK, c, 1'b0);
         chk($sformatf("atk_act_c%0d", c),
             int'(bus.o_hitbox_active), (c >= 6 && c <= 11) ? 1 : 0);
         chk($sformatf("atk_hit_c%0d", c),
             int'(bus.o_hit), (c == 6) ? 1 : 0);
      end
      chk("atk_hits", hits, 1);
      chk("atk_dmg", int'(bus.o_damage), 5);
      cyc(ST_IDLE, 0, 1'b0);
      chk("dmg_hold", int'(bus.o_damage), 5);

      do_reset();
      bus.i_opp_x = 10'd204;
      for (int c = 0; c <= 23; c++) cyc(ST_ATTACK, c, 1'b0);
      chk("reach_edge_hits", hits, 0);

      do_reset();
      bus.i_opp_x = 10'd300;
      for (int c = 0; c <= 7; c++) begin
         cyc(ST_DIR_ATTACK, c, 1'b1);
         chk($sformatf("lunge_x_c%0d", c),
             int'(bus.o_x), 100 + 4 * (c + 1));
      end
      cyc(ST_DIR_ATTACK, 8, 1'b1);
      chk("dir_c8_x", int'(bus.o_x), 132);
      chk("dir_c8_act", int'(bus.o_hitbox_active), 1);
      for (int c = 9; c <= 13; c++) cyc(ST_DIR_ATTACK, c, 1'b0);
      chk("dir_far_hits", hits, 0);

      do_reset();
      bus.i_opp_x = 10'd184;
      for (int c = 0; c <= 7; c++) cyc(ST_ATTACK, c, 1'b0);
      cyc(ST_IDLE, 0, 1'b0);
      for (int c = 0; c <= 7; c++) cyc(ST_ATTACK, c, 1'b0);
      chk("reattack_hits", hits, 2);
      cyc(ST_IDLE, 0, 1'b0);
      for (int c = 0; c <= 9; c++) cyc(ST_DIR_ATTACK, c, 1'b0);
      chk("dir_hit_cnt", hits, 3);
      chk("dir_dmg", int'(bus.o_damage), 8);
      chk("dir_hit_x", int'(bus.o_x), 100);

      do_reset();
      bus.i_opp_x = 10'd184;
      for (int c = 0; c <= 6; c++) cyc(ST_ATTACK, c, 1'b1);
      bus.i_count = 5'd7;
      #2;
      nRst = 1'b0;
      #1;
      chk("mid_rst_x", int'(bus.o_x), 100);
      chk("mid_rst_hit", int'(bus.o_hit), 0);
      chk("mid_rst_act", int'(bus.o_hitbox_active), 0);
      hits = 0;
      for (int c = 7; c <= 11; c++) cyc(ST_ATTACK, c, 1'b0);
      @(negedge clk);
      nRst = 1'b1;
      cyc(ST_IDLE, 0, 1'b0);
      chk("post_rst_hits", hits, 0);
      chk("post_rst_x", int'(bus.o_x), 100);
      chk("post_rst_dmg", int'(bus.o_damage), 0);

      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, errors);
      $finish;
   end

endmodule
